calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Multi-cycle arithmetic sequencer between `interface` and the display path. It replaces the single-shot `calculate` evaluation with a start/busy/done handshake on `sw_clk`. It performs add and subtract in one step, and multiply, divide and modulo by 32 shift iterations over a shared adder. It flags divide-by-zero, signed overflow and invalid operators by returning the segment error code.

## Interface
- `DIV_ERR_CODE`, default 32'h00EE_0000: value driven on `ans` when `err` is set; `segment_driver` renders it as "Error".
- `ITER`, default 32: shift iterations for multiply, divide and modulo. Fixed at 32; exists for bench visibility only.
- `sw_clk`, input, 1: the only clock; everything is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request pulse. Sampled only in IDLE.
- `operand1`, input, 32: signed two's complement operand, sampled with `start`.
- `operand2`, input, 32: signed two's complement operand, sampled with `start`.
- `operator`, input, 3: 1 = multiply, 2 = divide, 3 = add, 4 = subtract, 5 = modulo. 0, 6 and 7 are invalid.
- `busy`, output, 1: high from acceptance through the cycle before `done`.
- `done`, output, 1: one-cycle pulse when `ans` and `err` update.
- `ans`, output, 32: signed result. Holds its value until the next `done`.
- `err`, output, 1: error flag for the last result. Holds its value until the next `done`.

## Operation
- States: IDLE, LOAD, ITER, FIX.
- IDLE:
  - `start` = 1 at an edge: latch operands and operator, go to LOAD, set `busy`.
  - `start` while `busy` is ignored; it is not queued.
- LOAD: compute the result sign, |op1| and |op2| as 32-bit unsigned (|−2^31| = 32'h8000_0000). Then branch:
  - Invalid operator: write `err` = 1, `ans` = `DIV_ERR_CODE`, return to IDLE with `done` = 1.
  - Add or subtract: 32-bit signed result. Signed overflow (operand signs vs. result sign) is an error; otherwise write `ans`, `err` = 0. Return to IDLE with `done` = 1.
  - Divide or modulo with op2 = 0: error, return to IDLE with `done` = 1.
  - Multiply, divide or modulo otherwise: go to ITER with the counter at 0.
- ITER, one iteration per cycle, counter 0..31, leaves for FIX on iteration 31:
  - Multiply: shift-add on magnitudes into a 64-bit product, LSB-first on |op2|.
  - Divide and modulo: restoring division, MSB-first. 32-bit quotient; 33-bit partial remainder so the subtract never aliases.
- FIX: apply signs, check the range, write `ans` and `err`, pulse `done`, return to IDLE.
  - Quotient sign = sign1 XOR sign2. Remainder sign = sign of op1 (truncating semantics, matching Verilog `/` and `%`).
  - Multiply overflow:
    - Positive result: magnitude > 2^31−1.
    - Negative result: magnitude > 2^31.
  - Divide: −2^31 / −1 is an overflow.
  - Zero magnitude is always reported as +0.
- On any error: `ans` = `DIV_ERR_CODE`, `err` = 1.
- Reset while not idle: abort immediately, go to IDLE, drive reset values, no `done`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `err` = 0, `ans` = 0, state IDLE, counter 0.
- Let `start` be sampled at edge k. State is LOAD after k, and `busy` = 1 from k.
- Short path (add, subtract, invalid, divide by zero):
  - Result and `done` register at edge k+1; `busy` falls at k+1.
  - Latency is 1 cycle.
- Long path (multiply, divide, modulo):
  - LOAD→ITER at k+1.
  - Iterations at edges k+2 … k+33.
  - FIX writes the result and `done` at k+34; `busy` falls at k+34.
  - Latency is 34 cycles.
- `done` and `busy` are never high together.
- A `start` in the `done` cycle is accepted, since the state is IDLE.
- Operand changes after edge k have no effect on the running operation.

## Test plan
- Short ops, with `done` exactly 1 cycle after start:
  - 10 + 101 → `ans` = 111, `err` = 0.
  - 10 − 101 → −91.
  - 32'h7FFF_FFFF + 1 → `err` = 1, `ans` = 32'h00EE_0000.
- Long ops, with `done` exactly 34 cycles after start and `busy` high for cycles 0..33:
  - −10 × 101 → −1010.
  - −10 × −101 → 1010.
  - 100000 × −500 → −50000000.
  - 65536 × 65536 → `err` = 1.
- Divide and modulo signs:
  - 100000 / −500 → −200; 100000 % −500 → 0.
  - −10 / 101 → 0; −10 % 101 → −10.
  - −10 / −101 → 0.
  - −2^31 / −1 → `err` = 1.
- Error paths, each 1-cycle latency with `err` = 1 and `ans` = 32'h00EE_0000:
  - 1023 / 0.
  - 1023 % 0.
  - operator = 6.
- Handshake:
  - `start` pulsed during ITER with other operands → ignored; first result unchanged.
  - `start` in the `done` cycle → accepted.
  - Back-to-back requests → each yields exactly one `done`.
- Reset mid-divide at iteration 10 → `busy` = 0, `ans` = 0, `err` = 0, and no `done` afterwards until a new `start`.

Source files
------------

// File: rtl/calc_sequencer.sv
// Start/busy/done arithmetic sequencer: add/sub in one step, multiply/divide/modulo
// by 32 shift iterations on operand magnitudes, with signs and range applied at the end.
module calc_sequencer #(
    parameter logic [31:0] DIV_ERR_CODE = 32'h00EE_0000,
    parameter int unsigned ITER         = 32
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [2:0]  operator,
    output logic        busy,
    output logic        done,
    output logic [31:0] ans,
    output logic        err
);
    localparam int unsigned     CntW    = $clog2(ITER);
    localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);
    localparam logic [2:0]      OpMul   = 3'd1;
    localparam logic [2:0]      OpDiv   = 3'd2;
    localparam logic [2:0]      OpAdd   = 3'd3;
    localparam logic [2:0]      OpSub   = 3'd4;
    localparam logic [2:0]      OpMod   = 3'd5;

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StFix} state_e;

    state_e          r_state, w_state;
    logic [31:0]     r_op1, w_op1, r_op2, w_op2;
    logic [2:0]      r_opr, w_opr;
    logic            r_neg, w_neg, r_sign1, w_sign1;
    logic [31:0]     r_mag2, w_mag2, r_quo, w_quo;
    logic [32:0]     r_rem, w_rem;
    logic [63:0]     r_mcand, w_mcand, r_prod, w_prod;
    logic [CntW-1:0] r_cnt, w_cnt;
    logic            r_busy, w_busy, r_done, w_done, r_err, w_err;
    logic [31:0]     r_ans, w_ans;

    logic [31:0] w_abs1, w_abs2, w_addsub;
    logic        w_addsub_ovf, w_short_err, w_ge;
    logic [32:0] w_trial, w_diff;
    logic [31:0] w_fix_mag, w_fix_val;
    logic        w_fix_neg, w_fix_ovf;

    assign w_abs1 = r_op1[31] ? -r_op1 : r_op1;
    assign w_abs2 = r_op2[31] ? -r_op2 : r_op2;

    // Subtraction overflows like an add of an operand with the flipped sign.
    assign w_addsub     = (r_opr == OpSub) ? r_op1 - r_op2 : r_op1 + r_op2;
    assign w_addsub_ovf = (r_op1[31] == (r_op2[31] ^ (r_opr == OpSub)))
                          && (w_addsub[31] != r_op1[31]);
    // Only add/sub can finish cleanly in LOAD; anything else here is invalid or divide-by-zero.
    assign w_short_err  = !((r_opr == OpAdd) || (r_opr == OpSub)) || w_addsub_ovf;

    assign w_trial = {r_rem[31:0], r_quo[31]};
    assign w_ge    = w_trial >= {1'b0, r_mag2};
    assign w_diff  = w_trial - {1'b0, r_mag2};

    always_comb begin
        w_fix_neg = 1'b0;
        w_fix_ovf = 1'b0;
        w_fix_mag = r_rem[31:0];
        case (r_opr)
            OpMul: begin
                w_fix_neg = r_neg;
                w_fix_mag = r_prod[31:0];
                w_fix_ovf = r_neg ? (r_prod > 64'h0000_0000_8000_0000)
                                  : (r_prod > 64'h0000_0000_7FFF_FFFF);
            end
            OpDiv: begin
                w_fix_neg = r_neg;
                w_fix_mag = r_quo;
                w_fix_ovf = !r_neg && r_quo[31];
            end
            default: begin
                w_fix_neg = r_sign1;
                w_fix_ovf = r_rem[32];
            end
        endcase
    end

    assign w_fix_val = w_fix_neg ? -w_fix_mag : w_fix_mag;

    always_comb begin
        w_state = r_state;
        w_op1   = r_op1;
        w_op2   = r_op2;
        w_opr   = r_opr;
        w_neg   = r_neg;
        w_sign1 = r_sign1;
        w_mag2  = r_mag2;
        w_quo   = r_quo;
        w_rem   = r_rem;
        w_mcand = r_mcand;
        w_prod  = r_prod;
        w_cnt   = r_cnt;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = r_err;
        w_ans   = r_ans;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_op1   = operand1;
                    w_op2   = operand2;
                    w_opr   = operator;
                    w_busy  = 1'b1;
                    w_state = StLoad;
                end
            end
            StLoad: begin
                w_neg   = r_op1[31] ^ r_op2[31];
                w_sign1 = r_op1[31];
                w_mag2  = w_abs2;
                w_cnt   = '0;
                w_prod  = '0;
                w_rem   = '0;
                w_mcand = {32'd0, w_abs1};
                // Multiplier shifts out LSB-first; dividend shifts out MSB-first.
                w_quo   = (r_opr == OpMul) ? w_abs2 : w_abs1;
                if ((r_opr == OpMul)
                    || (((r_opr == OpDiv) || (r_opr == OpMod)) && (r_op2 != '0))) begin
                    w_state = StIter;
                end else begin
                    w_state = StIdle;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_err   = w_short_err;
                    w_ans   = w_short_err ? DIV_ERR_CODE : w_addsub;
                end
            end
            StIter: begin
                if (r_opr == OpMul) begin
                    if (r_quo[0]) w_prod = r_prod + r_mcand;
                    w_mcand = r_mcand << 1;
                    w_quo   = r_quo >> 1;
                end else begin
                    w_rem = w_ge ? w_diff : w_trial;
                    w_quo = {r_quo[30:0], w_ge};
                end
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == CntLast) w_state = StFix;
            end
            StFix: begin
                w_state = StIdle;
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_err   = w_fix_ovf;
                w_ans   = w_fix_ovf ? DIV_ERR_CODE : w_fix_val;
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_op1   <= '0;
            r_op2   <= '0;
            r_opr   <= '0;
            r_neg   <= 1'b0;
            r_sign1 <= 1'b0;
            r_mag2  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ans   <= '0;
        end else begin
            r_state <= w_state;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_opr   <= w_opr;
            r_neg   <= w_neg;
            r_sign1 <= w_sign1;
            r_mag2  <= w_mag2;
            r_quo   <= w_quo;
            r_rem   <= w_rem;
            r_mcand <= w_mcand;
            r_prod  <= w_prod;
            r_cnt   <= w_cnt;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
            r_ans   <= w_ans;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ans  = r_ans;
    assign err  = r_err;
endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed and random operations checked against a
// 64-bit integer arithmetic model of results, errors and latency.
module tb_calc_sequencer;
    logic        sw_clk;
    logic        rst;
    logic        start;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  operator;
    logic        busy;
    logic        done;
    logic [31:0] ans;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ErrCode = 32'h00EE_0000;

    calc_sequencer #(
        .DIV_ERR_CODE(ErrCode),
        .ITER        (32)
    ) dut (
        .sw_clk  (sw_clk),
        .rst     (rst),
        .start   (start),
        .operand1(operand1),
        .operand2(operand2),
        .operator(operator),
        .busy    (busy),
        .done    (done),
        .ans     (ans),
        .err     (err)
    );

    initial sw_clk = 1'b0;
    always #5 sw_clk = ~sw_clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits, then a 32-bit range check.
    task automatic ref_calc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            output logic [31:0] ea, output logic ee, output int elat);
        longint sa, sb, r;
        bit     bad;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        r    = 0;
        bad  = 1'b0;
        elat = 1;
        case (op)
            3'd1: begin r = sa * sb; elat = 34; end
            3'd2: if (sb == 0) bad = 1'b1; else begin r = sa / sb; elat = 34; end
            3'd3: r = sa + sb;
            3'd4: r = sa - sb;
            3'd5: if (sb == 0) bad = 1'b1; else begin r = sa % sb; elat = 34; end
            default: bad = 1'b1;
        endcase
        if (!bad && (r > 64'sd2147483647 || r < -64'sd2147483648)) bad = 1'b1;
        ee = bad;
        ea = bad ? ErrCode : r[31:0];
    endtask

    // Called at a falling edge; start is sampled at the next rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        start    = 1'b1;
        operand1 = a;
        operand2 = b;
        operator = op;
        @(negedge sw_clk);
        start    = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        operator = 3'($urandom);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] ea, input logic ee,
                             input int elat, input int inject_at);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        check({tag, " busy_at_accept"}, 32'(busy), 32'd1);
        check({tag, " no_done_at_accept"}, 32'(done), 32'd0);
        while (!seen && lat < 40) begin
            start = (lat == inject_at);
            if (lat == inject_at) begin
                operand1 = $urandom;
                operand2 = $urandom;
                operator = 3'd3;
            end
            @(negedge sw_clk);
            lat++;
            if (done === 1'b1) seen = 1'b1;
            else check({tag, " busy_while_running"}, 32'(busy), 32'd1);
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
        check({tag, " err"}, 32'(err), 32'(ee));
        check({tag, " ans"}, ans, ea);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input bit b2b);
        logic [31:0] ea;
        logic        ee;
        int          elat;
        ref_calc(a, b, op, ea, ee, elat);
        if (!b2b) @(negedge sw_clk);
        issue(a, b, op);
        wait_done(tag, ea, ee, elat, -1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge sw_clk);
            check({tag, " no_extra_done"}, 32'(done), 32'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return 32'($urandom_range(0, 2000)) - 32'd1000;
            2: return 32'd0;
            3: case ($urandom_range(0, 3))
                   0: return 32'h8000_0000;
                   1: return 32'hFFFF_FFFF;
                   2: return 32'h7FFF_FFFF;
                   default: return 32'd1;
               endcase
            default: return 32'($urandom_range(0, 70000));
        endcase
    endfunction

    initial begin
        logic [31:0] ea;
        logic        ee;
        int          elat;
        bit          seen;

        rst      = 1'b0;
        start    = 1'b0;
        operand1 = '0;
        operand2 = '0;
        operator = '0;
        repeat (3) @(negedge sw_clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset ans", ans, 32'd0);
        rst = 1'b1;

        run_op("add", 32'd10, 32'd101, 3'd3, 1'b0);
        run_op("sub", 32'd10, 32'd101, 3'd4, 1'b0);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'd3, 1'b0);
        run_op("sub_ovf", 32'h8000_0000, 32'd1, 3'd4, 1'b0);
        run_op("mul_neg", -32'sd10, 32'd101, 3'd1, 1'b0);
        run_op("mul_negneg", -32'sd10, -32'sd101, 3'd1, 1'b0);
        run_op("mul_big", 32'd100000, -32'sd500, 3'd1, 1'b0);
        run_op("mul_ovf", 32'd65536, 32'd65536, 3'd1, 1'b0);
        run_op("mul_minint", 32'h8000_0000, 32'd1, 3'd1, 1'b0);
        run_op("div_neg", 32'd100000, -32'sd500, 3'd2, 1'b0);
        run_op("mod_zero", 32'd100000, -32'sd500, 3'd5, 1'b0);
        run_op("div_small", -32'sd10, 32'd101, 3'd2, 1'b0);
        run_op("mod_neg", -32'sd10, 32'd101, 3'd5, 1'b0);
        run_op("div_negneg", -32'sd10, -32'sd101, 3'd2, 1'b0);
        run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 1'b0);
        run_op("div_by0", 32'd1023, 32'd0, 3'd2, 1'b0);
        run_op("mod_by0", 32'd1023, 32'd0, 3'd5, 1'b0);
        run_op("bad_op6", 32'd5, 32'd7, 3'd6, 1'b0);
        run_op("bad_op0", 32'd5, 32'd7, 3'd0, 1'b0);

        // Start during ITER must be dropped, not queued.
        ref_calc(32'd100000, -32'sd500, 3'd2, ea, ee, elat);
        @(negedge sw_clk);
        issue(32'd100000, -32'sd500, 3'd2);
        wait_done("ignored_start", ea, ee, elat, 5);
        quiet("ignored_start", 5);

        // Start raised in the done cycle is accepted; back-to-back gives one done each.
        run_op("b2b_first", 32'd1234, -32'sd77, 3'd1, 1'b0);
        run_op("b2b_done_cycle", -32'sd99999, 32'd7, 3'd5, 1'b1);
        run_op("b2b_short", 32'd3, 32'd4, 3'd4, 1'b1);
        quiet("b2b", 4);

        // Abort a divide at iteration 10.
        @(negedge sw_clk);
        issue(32'd123456, 32'd7, 3'd2);
        repeat (11) @(negedge sw_clk);
        rst = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort ans", ans, 32'd0);
        check("abort err", 32'(err), 32'd0);
        @(negedge sw_clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sw_clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort no_done_after", 32'(seen), 32'd0);
        check("abort stays_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), pick(), pick(), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)));
        end

        @(negedge sw_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
